mem_system_2way: RTL

MEM_SYSTEM_2WAY -- requirements
Module: mem_system_2way

---
 rtl/mem_system_2way.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_system_2way.sv
// mem_system_2way
//   Two-way set-associative, write-back, write-allocate cache in front of a
//   pipelined memory port. One CPU request is serviced at a time.
//
//   Address layout: {tag, index, word, byte}. Bit 0 selects the byte and must
//   be 0, because every access is one word wide.
//
//   Handshakes:
//     CPU side: Rd or Wr, with Addr and DataIn, is held stable until Done.
//       Done is a one-cycle pulse. DataOut is meaningful only while Done=1 for
//       a read. Stall is high whenever a request is in progress.
//     Memory side: a request (mem_req, mem_we, mem_addr, mem_wdata) transfers
//       on a cycle where mem_req && mem_gnt. While mem_req is high and mem_gnt
//       is low, the request stays unchanged. Read data returns in issue order
//       on mem_rvalid/mem_rdata, one cycle or more after the grant.
//
//   Ports:
//     clk, rst_n                    clock; asynchronous active-low reset
//     Addr, DataIn, Rd, Wr          CPU request
//     DataOut, Done, Stall,         CPU response
//     CacheHit, err
//     mem_req, mem_we, mem_addr,    memory request
//     mem_wdata, mem_gnt
//     mem_rvalid, mem_rdata         memory read return
//     dbg_state                     current FSM state, for observation only
//
//   Build option CACHE_LRU_EN:
//     defined   - one LRU bit per set picks the victim.
//     undefined - one global round-robin bit picks the victim.
module mem_system_2way #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int INDEX_W    = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              CacheHit,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        dbg_state
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WORD_W + 1;
  localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W;
  localparam int SETS   = 1 << INDEX_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, COMPARE, WB, FILL, RESP, ERR} state_t;
  state_t state, state_nxt;

  // Latched request. Bit 0 is always 0 once a request is accepted, so it is
  // not stored.
  logic [ADDR_W-1:1] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_we;

  logic              victim;       // way being written back / filled
  logic [WORD_W-1:0] issue_cnt;    // next word to request
  logic [WORD_W-1:0] ret_cnt;      // next word expected back
  logic              issue_done;   // all fill reads issued

  logic [SETS-1:0]   valid_w [2];
  logic [SETS-1:0]   dirty_w [2];
  logic [TAG_W-1:0]  tag_mem [2][SETS];
  logic [DATA_W-1:0] data_mem [2][SETS*LINE_WORDS];

  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [WORD_W-1:0]  req_word;
  assign req_idx  = req_addr[OFF_W +: INDEX_W];
  assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
  assign req_word = req_addr[1 +: WORD_W];

  logic hit0, hit1, hit;
  assign hit0 = valid_w[0][req_idx] && (tag_mem[0][req_idx] == req_tag);
  assign hit1 = valid_w[1][req_idx] && (tag_mem[1][req_idx] == req_tag);
  assign hit  = hit0 || hit1;

  logic repl_way;
  logic pick_way;
  logic victim_dirty;
  always_comb begin
    pick_way = repl_way;
    if (!valid_w[0][req_idx])      pick_way = 1'b0;
    else if (!valid_w[1][req_idx]) pick_way = 1'b1;
  end
  assign victim_dirty = valid_w[pick_way][req_idx] && dirty_w[pick_way][req_idx];

  logic start;
  assign start = (state == IDLE) && (Rd ^ Wr) && !Addr[0];

  // In COMPARE, the array is accessed through the hit way. In RESP, it is
  // accessed through the freshly filled way.
  logic              acc_way;
  logic [DATA_W-1:0] rd_word;
  assign acc_way = (state == COMPARE) ? hit1 : victim;
  assign rd_word = data_mem[acc_way][{req_idx, req_word}];

  logic fill_we, fill_last, cpu_we;
  assign fill_we   = (state == FILL) && mem_rvalid;
  assign fill_last = fill_we && (ret_cnt == LAST_WORD);
  assign cpu_we    = req_we && (((state == COMPARE) && hit) || (state == RESP));

  // Replacement state.
`ifdef CACHE_LRU_EN
  logic [SETS-1:0] lru;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lru <= '0;
    end else if ((state == COMPARE) && hit) begin
      lru[req_idx] <= ~hit1;
    end else if (fill_last) begin
      lru[req_idx] <= ~victim;
    end
  end
  assign repl_way = lru[req_idx];
`else
  logic rr_bit;
  logic need_repl;
  assign need_repl = valid_w[0][req_idx] && valid_w[1][req_idx];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_bit <= 1'b0;
    end else if ((state == COMPARE) && !hit && need_repl) begin
      rr_bit <= ~rr_bit;
    end
  end
  assign repl_way = rr_bit;
`endif

  // Data and tag arrays have no reset. Their valid bits guard their contents.
  // While reset is asserted, the FSM is in IDLE, which blocks every write.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[victim][{req_idx, ret_cnt}] <= mem_rdata;
    end else if (cpu_we) begin
      data_mem[acc_way][{req_idx, req_word}] <= req_wdata;
    end
    if (fill_last) begin
      tag_mem[victim][req_idx] <= req_tag;
    end
  end

  // Request latch, counters, and per-line status bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr   <= '0;
      req_wdata  <= '0;
      req_we     <= 1'b0;
      victim     <= 1'b0;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      issue_done <= 1'b0;
      valid_w[0] <= '0;
      valid_w[1] <= '0;
      dirty_w[0] <= '0;
      dirty_w[1] <= '0;
    end else begin
      if (start) begin
        req_addr  <= Addr[ADDR_W-1:1];
        req_wdata <= DataIn;
        req_we    <= Wr;
      end
      if (state == COMPARE) begin
        if (hit) begin
          if (req_we) dirty_w[hit1][req_idx] <= 1'b1;
        end else begin
          // The victim line is invalid from here until its fill completes.
          // An abort therefore never leaves a half-filled line marked valid.
          victim                     <= pick_way;
          valid_w[pick_way][req_idx] <= 1'b0;
          issue_cnt                  <= '0;
          ret_cnt                    <= '0;
          issue_done                 <= 1'b0;
        end
      end
      if ((state == WB) && mem_gnt) begin
        issue_cnt <= issue_cnt + WORD_W'(1);
      end
      if ((state == FILL) && !issue_done && mem_gnt) begin
        issue_cnt <= issue_cnt + WORD_W'(1);
        if (issue_cnt == LAST_WORD) issue_done <= 1'b1;
      end
      if (fill_we) begin
        ret_cnt <= ret_cnt + WORD_W'(1);
      end
      if (fill_last) begin
        valid_w[victim][req_idx] <= 1'b1;
        dirty_w[victim][req_idx] <= 1'b0;
      end
      if ((state == RESP) && req_we) begin
        dirty_w[victim][req_idx] <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and outputs.
  always_comb begin
    state_nxt = state;
    Done      = 1'b0;
    CacheHit  = 1'b0;
    err       = 1'b0;
    DataOut   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      IDLE: begin
        if ((Rd || Wr) && Addr[0]) begin
          state_nxt = ERR;
        end else if (Rd ^ Wr) begin
          state_nxt = COMPARE;
        end else if (Rd && Wr) begin
          err = 1'b1;
        end
      end
      COMPARE: begin
        if (hit) begin
          Done      = 1'b1;
          CacheHit  = 1'b1;
          DataOut   = req_we ? '0 : rd_word;
          state_nxt = IDLE;
        end else begin
          state_nxt = victim_dirty ? WB : FILL;
        end
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_mem[victim][req_idx], req_idx, issue_cnt, 1'b0};
        mem_wdata = data_mem[victim][{req_idx, issue_cnt}];
        if (mem_gnt && (issue_cnt == LAST_WORD)) state_nxt = FILL;
      end
      FILL: begin
        mem_req  = !issue_done;
        mem_addr = {req_tag, req_idx, issue_cnt, 1'b0};
        if (fill_last) state_nxt = RESP;
      end
      RESP: begin
        Done      = 1'b1;
        DataOut   = req_we ? '0 : rd_word;
        state_nxt = IDLE;
      end
      ERR: begin
        Done      = 1'b1;
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Stall     = (state != IDLE);
  assign dbg_state = state;

endmodule
